// File: rtl/csr_hpm_counters_pkg.sv
// Shared definitions for the counter CSR bank: addresses, mhpmevent field
// positions, privilege encoding and the implemented-counter mask.
package csr_hpm_counters_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  localparam logic [11:0] CSR_MCYCLE_ADDR        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH_ADDR       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE_ADDR         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH_ADDR        = 12'hC80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3_ADDR    = 12'h323;
  localparam logic [11:0] CSR_M_COUNTEREN_ADDR   = 12'h306;
  localparam logic [11:0] CSR_S_COUNTEREN_ADDR   = 12'h106;

  localparam logic [31:0] CSR_COUNTEREN_DEFAULT = 32'hFFFF_FFFF;

  localparam int MHPMEVENT_OF_BIT = 31;
  localparam int MHPMEVENT_IE_BIT = 30;

  // Bits 0 (cycle), 2 (instret) and 3..3+num_hpm-1; bit 1 (time) never exists here.
  function automatic logic [31:0] counteren_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 3; i < 32; i++) begin
      if (i < 3 + num_hpm) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_hpm_counters_if.sv
// CSR access bus between the main CSR file (master) and the counter bank (slave).
interface csr_hpm_counters_if;
  logic [11:0] csr_addr_i;
  logic        csr_re_i;
  logic        csr_we_i;
  logic [31:0] csr_wdata_i;
  logic        csr_hit_o;
  logic        csr_illegal_o;
  logic [31:0] csr_rdata_o;

  modport master (
    output csr_addr_i, csr_re_i, csr_we_i, csr_wdata_i,
    input  csr_hit_o, csr_illegal_o, csr_rdata_o
  );

  modport slave (
    input  csr_addr_i, csr_re_i, csr_we_i, csr_wdata_i,
    output csr_hit_o, csr_illegal_o, csr_rdata_o
  );
endinterface

// File: rtl/csr_hpm_counters_hpm_counter.sv
// One counter slice: CSR half-writes win over the increment; wrap flags an
// all-ones to zero roll-over that actually happens this cycle.
module csr_hpm_counters_hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inhibit,
  input  logic                 inc,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 wrap
);

  logic step;
  logic unused_wdata;

  assign step         = inc && !inhibit && !we_lo && !we_hi;
  assign wrap         = step && (&cnt);
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (we_lo) cnt[31:0] <= wdata;
    else if (we_hi) cnt[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
    else if (step)  cnt <= cnt + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/csr_hpm_counters.sv
// Counter CSR bank: mcycle, minstret and NUM_HPM event counters with inhibit,
// event select, sticky overflow + interrupt, and privilege-gated shadows.
module csr_hpm_counters
  import csr_hpm_counters_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  priv_e                 priv_i,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  csr_hpm_counters_if.slave     csr,
  output logic                  ovf_irq_o
);

  localparam int          SEL_W    = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] CNT_MASK = counteren_mask(NUM_HPM);
  localparam logic [31:0] EN_RST   = CSR_COUNTEREN_DEFAULT & CNT_MASK;

  logic [31:0][63:0] cnt_tab;
  logic [31:0][31:0] evt_tab;
  logic [31:0]       ovf_vec;
  logic [31:0]       minh_q, men_q, sen_q;

  logic [11:0] addr;
  logic [4:0]  idx;
  logic        hit, bad, is_m, sh_ok, wr_ok;
  logic [31:0] rd;

  assign addr = csr.csr_addr_i;
  assign idx  = addr[4:0];

  // Decode and legality; everything is combinational so the read returns in the strobe cycle.
  always_comb begin
    hit   = 1'b0;
    bad   = 1'b0;
    rd    = '0;
    is_m  = (priv_i == PRIV_M);
    sh_ok = is_m
         || (priv_i == PRIV_S && men_q[idx])
         || (priv_i == PRIV_U && men_q[idx] && sen_q[idx]);
    if (addr[11:5] == CSR_MCYCLE_ADDR[11:5]) begin
      hit = 1'b1;
      bad = !is_m || !CNT_MASK[idx];
      rd  = cnt_tab[idx][31:0];
    end else if (addr[11:5] == CSR_MCYCLEH_ADDR[11:5]) begin
      hit = 1'b1;
      bad = !is_m || !CNT_MASK[idx];
      rd  = cnt_tab[idx][63:32];
    end else if (addr[11:5] == CSR_CYCLE_ADDR[11:5]) begin
      hit = 1'b1;
      bad = csr.csr_we_i || !CNT_MASK[idx] || !sh_ok;
      rd  = cnt_tab[idx][31:0];
    end else if (addr[11:5] == CSR_CYCLEH_ADDR[11:5]) begin
      hit = 1'b1;
      bad = csr.csr_we_i || !CNT_MASK[idx] || !sh_ok;
      rd  = cnt_tab[idx][63:32];
    end else if (addr == CSR_MCOUNTINHIBIT_ADDR) begin
      hit = 1'b1;
      bad = !is_m;
      rd  = minh_q;
    end else if (addr[11:5] == CSR_MCOUNTINHIBIT_ADDR[11:5] && idx >= 5'd3) begin
      hit = 1'b1;
      bad = !is_m || !CNT_MASK[idx];
      rd  = evt_tab[idx];
    end else if (addr == CSR_M_COUNTEREN_ADDR) begin
      hit = 1'b1;
      bad = !is_m;
      rd  = men_q;
    end else if (addr == CSR_S_COUNTEREN_ADDR) begin
      hit = 1'b1;
      bad = (priv_i == PRIV_U);
      rd  = sen_q;
    end
  end

  assign csr.csr_hit_o     = hit;
  assign csr.csr_illegal_o = bad && (csr.csr_re_i || csr.csr_we_i);
  assign csr.csr_rdata_o   = (csr.csr_re_i && hit && !bad) ? rd : '0;
  assign wr_ok             = csr.csr_we_i && hit && !bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minh_q    <= '0;
      men_q     <= EN_RST;
      sen_q     <= EN_RST;
      ovf_irq_o <= 1'b0;
    end else begin
      if (wr_ok && addr == CSR_MCOUNTINHIBIT_ADDR) minh_q <= csr.csr_wdata_i & CNT_MASK;
      if (wr_ok && addr == CSR_M_COUNTEREN_ADDR)   men_q  <= csr.csr_wdata_i & CNT_MASK;
      if (wr_ok && addr == CSR_S_COUNTEREN_ADDR)   sen_q  <= csr.csr_wdata_i & CNT_MASK;
      ovf_irq_o <= |ovf_vec;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if (CNT_MASK[i]) begin : g_impl
      logic                 src, wr_lo, wr_hi, wrap;
      logic [CNT_WIDTH-1:0] cnt;

      assign wr_lo      = wr_ok && (addr == 12'(CSR_MCYCLE_ADDR + i));
      assign wr_hi      = wr_ok && (addr == 12'(CSR_MCYCLEH_ADDR + i));
      assign cnt_tab[i] = 64'(cnt);

      if (i >= 3) begin : g_evt
        logic             of_q, ie_q, wr_evt;
        logic [SEL_W-1:0] sel_q;

        assign wr_evt = wr_ok && (addr == 12'(CSR_MHPMEVENT3_ADDR + i - 3));

        // A hardware wrap in the same cycle as a CSR write to OF takes priority.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            of_q  <= 1'b0;
            ie_q  <= 1'b0;
            sel_q <= '0;
          end else begin
            if (wr_evt) begin
              of_q  <= csr.csr_wdata_i[MHPMEVENT_OF_BIT];
              ie_q  <= csr.csr_wdata_i[MHPMEVENT_IE_BIT];
              sel_q <= csr.csr_wdata_i[SEL_W-1:0];
            end
            if (wrap) of_q <= 1'b1;
          end
        end

        always_comb begin
          src = 1'b0;
          for (int k = 1; k <= NUM_EVENTS; k++) begin
            if (int'(sel_q) == k) src = event_i[k-1];
          end
        end

        assign evt_tab[i] = {of_q, ie_q, {(30-SEL_W){1'b0}}, sel_q};
        assign ovf_vec[i] = of_q & ie_q;
      end else begin : g_fix
        logic unused_wrap;
        assign unused_wrap = wrap;
        assign src         = (i == 0) ? 1'b1 : retire_i;
        assign evt_tab[i]  = '0;
        assign ovf_vec[i]  = 1'b0;
      end

      csr_hpm_counters_hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (minh_q[i]),
        .inc     (src),
        .we_lo   (wr_lo),
        .we_hi   (wr_hi),
        .wdata   (csr.csr_wdata_i),
        .cnt     (cnt),
        .wrap    (wrap)
      );
    end else begin : g_none
      assign cnt_tab[i] = '0;
      assign evt_tab[i] = '0;
      assign ovf_vec[i] = 1'b0;
    end
  end

endmodule
